// File: rtl/mpemu_pipe.sv
// Pipelined signed multiplier with a selectable product bit window.
// Adds optional round-half-up, saturation, a valid pipeline and a clock-enable stall.
module mpemu_pipe #(
  parameter int A_W      = 24,
  parameter int B_W      = 24,
  parameter int B_SIGNED = 1,
  parameter int LSB      = 19,
  parameter int OUT_W    = 28,
  parameter int LATENCY  = 5,
  parameter int ROUND    = 0,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             valid_i,
  input  logic [A_W-1:0]   mpcand_i,
  input  logic [B_W-1:0]   mplier_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] mprod_o,
  output logic             sat_o
);

  localparam int P_W     = A_W + B_W + ((B_SIGNED != 0) ? 0 : 1);
  // Two guard bits hold the rounding carry and keep R sign-correct for either B mode.
  localparam int R_W     = A_W + B_W + 2;
  localparam int DEPTH   = LATENCY - 1;
  localparam int RND_POS = (LSB > 0) ? LSB - 1 : 0;
  localparam logic [R_W-1:0] RND_ADD =
    (ROUND != 0) ? ({{(R_W-1){1'b0}}, 1'b1} << RND_POS) : '0;
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  if (LSB + OUT_W > P_W) begin : g_err_window
    $error("mpemu_pipe: LSB + OUT_W exceeds the full product width");
  end
  if (ROUND != 0 && LSB < 1) begin : g_err_round
    $error("mpemu_pipe: rounding needs LSB >= 1");
  end
  if (LATENCY < 2 || LATENCY > 16) begin : g_err_latency
    $error("mpemu_pipe: LATENCY must be within 2..16");
  end

  // Operand delay line; the multiply and windowing happen in the final stage.
  logic [A_W-1:0]   r_a [DEPTH];
  logic [B_W-1:0]   r_b [DEPTH];
  logic [DEPTH-1:0] r_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data stages are cleared too, so mprod_o is deterministic straight out of reset.
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (ce_i) begin
      // NOTE: non-blocking updates let each stage read its neighbour's old value.
      r_v[0] <= valid_i;
      r_a[0] <= mpcand_i;
      r_b[0] <= mplier_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i] <= r_v[i-1];
        r_a[i] <= r_a[i-1];
        r_b[i] <= r_b[i-1];
      end
    end
  end

  logic signed [A_W-1:0]   w_a;
  logic signed [B_W:0]     w_b_ext;
  logic signed [R_W-1:0]   w_prod;
  logic signed [R_W-1:0]   w_r;
  logic signed [R_W-1:0]   w_sh;
  logic [OUT_W-1:0]        w_win;
  logic [R_W-OUT_W:0]      w_top;
  logic                    w_ovf;
  logic                    w_pos;

  assign w_a     = signed'(r_a[DEPTH-1]);
  assign w_b_ext = (B_SIGNED != 0) ? signed'({r_b[DEPTH-1][B_W-1], r_b[DEPTH-1]})
                                   : signed'({1'b0, r_b[DEPTH-1]});
  assign w_prod  = R_W'(w_a) * R_W'(w_b_ext);
  assign w_r     = w_prod + signed'(RND_ADD);
  assign w_sh    = w_r >>> LSB;
  assign w_win   = w_sh[OUT_W-1:0];
  // Window MSB plus every bit above it must agree, otherwise the value does not fit.
  assign w_top   = w_sh[R_W-1:OUT_W-1];
  assign w_ovf   = !((&w_top) || !(|w_top));
  assign w_pos   = !w_r[R_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      mprod_o <= '0;
      sat_o   <= 1'b0;
    end else if (ce_i) begin
      valid_o <= r_v[DEPTH-1];
      if (SATURATE != 0 && w_ovf) begin
        mprod_o <= w_pos ? SAT_POS : SAT_NEG;
        sat_o   <= 1'b1;
      end else begin
        mprod_o <= w_win;
        sat_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mpemu_pipe.sv
// Directed bench for mpemu_pipe: defaults, saturate, round and a wide unsigned-B build
// share one stimulus stream; expected values are hand-computed constants.
module tb_mpemu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        valid;
  logic [23:0] a;
  logic [23:0] b;
  logic [31:0] b32;

  logic        def_v, sat_v, rnd_v, wide_v;
  logic [27:0] def_p, sat_p, rnd_p;
  logic [31:0] wide_p;
  logic        def_s, sat_s, rnd_s, wide_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mpemu_pipe u_def (
    .clk(clk), .rst(rst), .ce_i(ce), .valid_i(valid), .mpcand_i(a), .mplier_i(b),
    .valid_o(def_v), .mprod_o(def_p), .sat_o(def_s)
  );

  mpemu_pipe #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .ce_i(ce), .valid_i(valid), .mpcand_i(a), .mplier_i(b),
    .valid_o(sat_v), .mprod_o(sat_p), .sat_o(sat_s)
  );

  mpemu_pipe #(.ROUND(1)) u_rnd (
    .clk(clk), .rst(rst), .ce_i(ce), .valid_i(valid), .mpcand_i(a), .mplier_i(b),
    .valid_o(rnd_v), .mprod_o(rnd_p), .sat_o(rnd_s)
  );

  mpemu_pipe #(.B_W(32), .B_SIGNED(0), .LSB(24), .OUT_W(32), .LATENCY(6)) u_wide (
    .clk(clk), .rst(rst), .ce_i(ce), .valid_i(valid), .mpcand_i(a), .mplier_i(b32),
    .valid_o(wide_v), .mprod_o(wide_p), .sat_o(wide_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single valid pulse; returns one cycle before the LATENCY=5 output is due.
  task automatic pulse(input logic [23:0] pa, input logic [23:0] pb, input logic [31:0] pb32);
    a     = pa;
    b     = pb;
    b32   = pb32;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(3);
  endtask

  int exp_out [17] = '{0, 0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7, 8, 0};

  initial begin
    rst = 1'b1; ce = 1'b1; valid = 1'b0; a = '0; b = '0; b32 = '0;
    tick(2);
    check("reset valid_o", 64'(def_v), 64'd0);
    check("reset mprod_o", 64'(def_p), 64'd0);
    check("reset sat_o",   64'(sat_s), 64'd0);
    check("reset wide valid_o", 64'(wide_v), 64'd0);
    rst = 1'b0;

    // 2^22 * 2^22 >> 19 = 2^25
    pulse(24'h400000, 24'h400000, 32'd0);
    check("t1 valid early", 64'(def_v), 64'd0);
    tick(1);
    check("t1 valid",  64'(def_v), 64'd1);
    check("t1 mprod",  64'(def_p), 64'h2000000);
    check("t1 sat",    64'(def_s), 64'd0);
    check("t1 satcfg mprod", 64'(sat_p), 64'h2000000);
    check("t1 satcfg sat",   64'(sat_s), 64'd0);
    tick(1);
    check("t1 valid single", 64'(def_v), 64'd0);

    // (-2^23)^2 >> 19 = 2^27 overflows the signed 28-bit window
    pulse(24'h800000, 24'h800000, 32'd0);
    tick(1);
    check("t2 sat mprod", 64'(sat_p), 64'h7FFFFFF);
    check("t2 sat flag",  64'(sat_s), 64'd1);
    check("t2 sat valid", 64'(sat_v), 64'd1);
    check("t2 wrap mprod", 64'(def_p), 64'h8000000);
    check("t2 wrap flag",  64'(def_s), 64'd0);
    tick(1);

    // 1 * 2^18: round gives 2^19 -> 1, truncate gives 0
    pulse(24'h000001, 24'h040000, 32'd0);
    tick(1);
    check("t3 round +", 64'(rnd_p), 64'd1);
    check("t3 round valid", 64'(rnd_v), 64'd1);
    check("t3 trunc +", 64'(def_p), 64'd0);
    tick(1);
    // -1 * 2^18: round gives 0, truncate gives -1
    pulse(24'hFFFFFF, 24'h040000, 32'd0);
    tick(1);
    check("t3 round -", 64'(rnd_p), 64'd0);
    check("t3 round sat", 64'(rnd_s), 64'd0);
    check("t3 trunc -", 64'(def_p), 64'hFFFFFFF);
    tick(1);

    // Wide build, LATENCY=6: 2^20 * 2^31 >> 24 = 2^27
    pulse(24'h100000, 24'd0, 32'h80000000);
    tick(1);
    check("t6 wide valid early", 64'(wide_v), 64'd0);
    tick(1);
    check("t6 wide valid", 64'(wide_v), 64'd1);
    check("t6 wide +", 64'(wide_p), 64'h08000000);
    check("t6 wide sat", 64'(wide_s), 64'd0);
    pulse(24'hF00000, 24'd0, 32'h80000000);
    tick(2);
    check("t6 wide -", 64'(wide_p), 64'hF8000000);
    tick(1);
    check("t6 wide valid single", 64'(wide_v), 64'd0);

    // Stream of 8 samples (value k+1 each) with a 3-cycle stall after the 3rd output
    b32 = '0;
    for (int t = 0; t <= 16; t++) begin
      check($sformatf("t4 valid c%0d", t), 64'(def_v), 64'(exp_out[t] != 0));
      if (exp_out[t] != 0) begin
        check($sformatf("t4 mprod c%0d", t), 64'(def_p), 64'(exp_out[t]));
        check($sformatf("t4 sat c%0d", t), 64'(def_s), 64'd0);
      end
      ce = !(t >= 7 && t <= 9);
      b  = 24'd1;
      if (t <= 6) begin
        valid = 1'b1;
        a     = 24'((t + 1) << 19);
      end else if (t == 10) begin
        valid = 1'b1;
        a     = 24'(8 << 19);
      end else begin
        valid = 1'b0;
      end
      tick(1);
    end
    ce = 1'b1;
    valid = 1'b0;

    // Reset two cycles after a valid sample discards it
    a = 24'h800000;
    b = 24'h800000;
    tick(6);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("t5 valid after rst", 64'(def_v), 64'd0);
    check("t5 mprod after rst", 64'(def_p), 64'd0);
    check("t5 satcfg mprod after rst", 64'(sat_p), 64'd0);
    check("t5 sat after rst", 64'(sat_s), 64'd0);
    rst   = 1'b0;
    valid = 1'b1;
    a     = 24'h400000;
    b     = 24'h400000;
    tick(1);
    valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("t5 valid +%0d", k), 64'(def_v), 64'(k == 5));
      if (k == 5) check("t5 mprod post", 64'(def_p), 64'h2000000);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
